// File: rtl/wb_la_initiator.sv
// Wishbone classic initiator: one single-beat read/write per command,
// bounded ack timeout, response with read data, error flag and counter.
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_we/sel/adr/dat          command fields
//   rsp_valid/rsp_ready         response handshake
//   rsp_dat, rsp_err            read data (0 for writes/errors), timeout flag
//   wbm_*                       Wishbone initiator bus
//   busy                        high while in BUS or RESP
//   txn_count                   completed transactions, errors included
module wb_la_initiator #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [3:0]       cmd_sel,
    input  logic [31:0]      cmd_adr,
    input  logic [31:0]      cmd_dat,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_dat,
    output logic             rsp_err,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic             wbm_ack_i,
    input  logic [31:0]      wbm_dat_i,
    output logic             busy,
    output logic [CNT_W-1:0] txn_count
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RESP
    } state_t;

    state_t           r_state;
    logic [TW-1:0]    r_tmo;
    logic             r_cmd_ready;
    logic             r_rsp_valid;
    logic [31:0]      r_rsp_dat;
    logic             r_rsp_err;
    logic             r_cyc;
    logic             r_stb;
    logic             r_we;
    logic [3:0]       r_sel;
    logic [31:0]      r_adr;
    logic [31:0]      r_dat;
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;

    // r_tmo counts completed BUS cycles without ack; the edge ending the
    // TIMEOUT-th BUS cycle sees TIMEOUT-1 and aborts.
    logic w_tmo_hit;
    assign w_tmo_hit = (r_tmo == TW'(TIMEOUT - 1));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= S_IDLE;
            r_tmo       <= '0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_sel       <= '0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_busy      <= 1'b0;
            r_cnt       <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_we        <= cmd_we;
                        r_sel       <= cmd_sel;
                        r_adr       <= cmd_adr;
                        r_dat       <= cmd_dat;
                        r_cyc       <= 1'b1;
                        r_stb       <= 1'b1;
                        r_tmo       <= '0;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_BUS;
                    end
                end
                S_BUS: begin
                    // Ack has priority over a coincident timeout.
                    if (wbm_ack_i) begin
                        r_cyc       <= 1'b0;
                        r_stb       <= 1'b0;
                        r_rsp_dat   <= r_we ? 32'h0 : wbm_dat_i;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_cnt       <= r_cnt + 1'b1;
                        r_state     <= S_RESP;
                    end else if (w_tmo_hit) begin
                        r_cyc       <= 1'b0;
                        r_stb       <= 1'b0;
                        r_rsp_dat   <= 32'h0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_cnt       <= r_cnt + 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_dat   = r_rsp_dat;
    assign rsp_err   = r_rsp_err;
    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_stb;
    assign wbm_we_o  = r_we;
    assign wbm_sel_o = r_sel;
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat;
    assign busy      = r_busy;
    assign txn_count = r_cnt;

endmodule

// File: doc/wb_la_initiator.md
Name: wb_la_initiator

Overview:
- Wishbone classic initiator that drives the shared user-project Wishbone bus from a simple command/response interface. The command side is fed from logic-analyzer bits or a test harness.
- Lets firmware or a bench exercise any wrapped user project as a bus responder without the management core.
- Issues one single-beat read or write at a time, waits for ack with a bounded timeout, and returns read data plus status.

Parameters:
- TIMEOUT, 255: max cycles with cyc/stb high and no ack before the transaction is aborted; must be >= 1.
- CNT_W, 16: width of the completed-transaction counter.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  initiator accepts command
- cmd_we  in  1  1 = write, 0 = read
- cmd_sel  in  4  byte selects
- cmd_adr  in  32  address
- cmd_dat  in  32  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_dat  out  32  read data; 0 for writes and errors
- rsp_err  out  1  1 = timeout abort
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  Wishbone write enable
- wbm_sel_o  out  4  Wishbone byte selects
- wbm_adr_o  out  32  Wishbone address
- wbm_dat_o  out  32  Wishbone write data
- wbm_ack_i  in  1  Wishbone acknowledge
- wbm_dat_i  in  32  Wishbone read data
- busy  out  1  high in BUS or RESP state
- txn_count  out  CNT_W  completed transactions, including errors

Behaviour:
- One clock, wb_clk_i. Reset wb_rst_i is synchronous and active-high. All outputs are registered.
- Reset values:
  - cmd_ready=1 (IDLE); rsp_valid=0; rsp_err=0; rsp_dat=0; busy=0; txn_count=0.
  - wbm_cyc_o=0, wbm_stb_o=0, wbm_we_o=0, wbm_sel_o=0, wbm_adr_o=0, wbm_dat_o=0.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready=1.
  - On an edge with cmd_valid=1: capture we/sel/adr/dat into the wbm_* registers, set cyc=stb=1, clear the timeout counter, go to BUS.
  - Command-to-bus latency is exactly 1 cycle: cyc/stb are high in the cycle after acceptance.
- BUS:
  - cmd_ready=0; cyc, stb, we, sel, adr and dat held stable.
  - Timeout counter increments each BUS cycle.
  - Edge with wbm_ack_i=1:
    - drop cyc/stb on that edge;
    - rsp_dat = wbm_dat_i for reads, 0 for writes;
    - rsp_err=0, rsp_valid=1;
    - increment txn_count; go to RESP.
  - Edge where the counter has reached TIMEOUT cycles with no ack:
    - drop cyc/stb; rsp_dat=0, rsp_err=1, rsp_valid=1;
    - increment txn_count; go to RESP.
  - Ack and timeout on the same edge: ack wins, rsp_err=0.
  - Minimum cmd-to-rsp_valid latency is 2 cycles: responder acks in the first BUS cycle.
- RESP:
  - rsp_valid, rsp_dat and rsp_err held stable until an edge with rsp_ready=1; that edge clears rsp_valid and returns to IDLE.
  - cmd_ready=0 throughout RESP. There is no command/response overlap; the next command is accepted one cycle after the response handshake at the earliest.
- wbm_ack_i outside BUS is ignored: no state change, no counter change.
- wbm_dat_o and wbm_adr_o keep their last value after a cycle ends; the responder must qualify them with cyc/stb.
- txn_count wraps from 2^CNT_W-1 to 0.
- Reset mid-operation: cyc/stb fall on the reset edge, a pending response is discarded, the FSM returns to IDLE, and txn_count is cleared.
- busy = (state != IDLE).

Test Plan:
- Write:
  - Stimulus: cmd we=1, sel=F, adr=0x3000_0000, dat=0x1234_5678; responder acks on the 3rd BUS cycle; rsp_ready=1.
  - Required: cyc/stb high exactly 3 cycles, we=1, adr/dat/sel stable; rsp_valid for 1 cycle with rsp_dat=0, rsp_err=0; txn_count=1.
- Read:
  - Stimulus: cmd we=0, adr=0x3000_0004; responder acks in the first BUS cycle with dat_i=0xCAFE_F00D.
  - Required: rsp_valid 2 cycles after acceptance, rsp_dat=0xCAFE_F00D, rsp_err=0.
- Timeout:
  - Stimulus: TIMEOUT=8, no ack.
  - Required: cyc/stb high exactly 8 cycles; rsp_err=1, rsp_dat=0; txn_count increments.
  - Variant: ack on the 8th cycle gives rsp_err=0 with the read data.
- Back-pressure:
  - Stimulus: rsp_ready=0 for 5 cycles after a read, cmd_valid held high with a second command.
  - Required: rsp fields stable, cmd_ready=0 throughout; second command accepted one cycle after the rsp handshake.
- Reset mid-BUS:
  - Stimulus: assert wb_rst_i on the 2nd BUS cycle.
  - Required: cyc/stb=0, rsp_valid=0, txn_count=0, cmd_ready=1 after that edge; a later ack is ignored.
- Stray ack:
  - Stimulus: pulse wbm_ack_i while IDLE and while in RESP.
  - Required: no state, response or counter change.
